// File: rtl/jk_excite_driver_pkg.sv
// jk_pkg: shared types and constants for the JK excitation driver.
//   state_t   : transfer sequencer states (IDLE, STEP, DONE)
//   JK_*      : {j,k} excitation codes for one JK flip-flop
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite_driver_cell.sv
// jk_excite_cell: per-bit JK excitation encoder (inverse JK characteristic).
// Build option: JK_EXCITE_TOGGLE_EN -- when defined, an enabled bit that must
// change is driven with toggle (11); otherwise set (10) / reset (01).
// Ports:
//   q      : present value of the flip-flop
//   q_next : desired value of the flip-flop
//   en     : this bit is the one being moved this cycle
//   jk     : {j,k} excitation, hold (00) when not enabled or already equal
module jk_excite_cell
    import jk_pkg::*;
(
    input  logic       q,
    input  logic       q_next,
    input  logic       en,
    output logic [1:0] jk
);

    always_comb begin
        jk = JK_HOLD;
        if (en && (q != q_next)) begin
`ifdef JK_EXCITE_TOGGLE_EN
            jk = JK_TOGGLE;
`else
            jk = q_next ? JK_SET : JK_RESET;
`endif
        end
    end

endmodule

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: walks an external WIDTH-bit JK register bank from its
// current value to a requested target, one bit per clock, LSB first, while
// keeping a shadow copy of the bank and counting bit flips.
// Build option: JK_EXCITE_TOGGLE_EN selects toggle excitation (see cell).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : target offered;  in_target : requested bank value
//   in_ready   : target accepted this cycle when in_valid is high
//   j, k       : excitation to the bank (combinational, zero during rst)
//   q_shadow   : registered model of the bank value
//   busy       : transfer in progress;  done : one-cycle completion pulse
//   flips      : total bits changed since reset, wraps at 2^CNT_W
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_target,
    output logic             in_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q_shadow,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] flips
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] flips_q, flips_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sel;
    logic             last_bit;
    logic             step_act;
    logic [1:0]       jk_w [WIDTH];

    assign diff     = target_q ^ shadow_q;
    // Two's-complement trick isolates the lowest set bit as a one-hot mask.
    assign sel      = diff & (~diff + WIDTH'(1));
    assign last_bit = (diff & (diff - WIDTH'(1))) == '0;
    // Excitation is suppressed while rst is high so the bank cannot move
    // on the edge that resets the shadow.
    assign step_act = (state_q == STEP) && !rst;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        shadow_d = shadow_q;
        flips_d  = flips_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    target_d = in_target;
                    state_d  = (in_target != shadow_q) ? STEP : DONE;
                end
            end
            STEP: begin
                shadow_d = shadow_q ^ sel;
                flips_d  = flips_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= RESET_VAL;
            shadow_q <= RESET_VAL;
            flips_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            shadow_q <= shadow_d;
            flips_q  <= flips_d;
            done_q   <= done_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_excite_cell u_cell (
            .q      (shadow_q[gi]),
            .q_next (target_q[gi]),
            .en     (sel[gi] & step_act),
            .jk     (jk_w[gi])
        );
        assign j[gi] = jk_w[gi][1];
        assign k[gi] = jk_w[gi][0];
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign q_shadow = shadow_q;
    assign flips    = flips_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model that turns each
// accepted target into a queue of bit indices to be moved.
module tb_jk_excite_driver;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_target = '0;
    logic             in_ready;
    logic [WIDTH-1:0] j, k, q_shadow;
    logic             busy, done;
    logic [CNT_W-1:0] flips;

    jk_excite_driver #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'h00),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_target (in_target),
        .in_ready  (in_ready),
        .j         (j),
        .k         (k),
        .q_shadow  (q_shadow),
        .busy      (busy),
        .done      (done),
        .flips     (flips)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: bank value, flip total, pending bit indices, done-cycle flag.
    int unsigned m_shadow = 0;
    int unsigned m_flips  = 0;
    int unsigned m_target = 0;
    int unsigned m_pend[$];
    bit          m_done   = 1'b0;
    bit          m_accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit m_idle();
        return (m_pend.size() == 0) && !m_done;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, then advance model at the edge.
    task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] t);
        int unsigned ej, ek, b;
        @(negedge clk);
        rst = r; in_valid = v; in_target = t;
        #1;
        ej = 0; ek = 0;
        if (!r && m_pend.size() != 0) begin
            b = m_pend[0];
`ifdef JK_EXCITE_TOGGLE_EN
            ej = 1 << b; ek = 1 << b;
`else
            if (m_target[b]) ej = 1 << b;
            else             ek = 1 << b;
`endif
        end
        check("j", 32'(j), ej);
        check("k", 32'(k), ek);
        check("in_ready", 32'(in_ready), 32'(m_idle()));
        check("busy", 32'(busy), 32'(!m_idle()));
        check("done", 32'(done), 32'(m_done));
        check("q_shadow", 32'(q_shadow), m_shadow);
        check("flips", 32'(flips), m_flips % (1 << CNT_W));
        check("onehot_jk", 32'($countones(j | k) <= 1), 32'd1);
        @(posedge clk);
        m_accepted = 1'b0;
        if (r) begin
            m_shadow = 0; m_flips = 0; m_done = 1'b0; m_pend.delete();
        end else if (m_pend.size() != 0) begin
            b = m_pend.pop_front();
            m_shadow = m_shadow ^ (1 << b);
            m_flips++;
            if (m_pend.size() == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (v) begin
            m_accepted = 1'b1;
            m_target = 32'(t);
            for (int i = 0; i < int'(WIDTH); i++)
                if (m_target[i] != m_shadow[i]) m_pend.push_back(i);
            if (m_pend.size() == 0) m_done = 1'b1;
        end
    endtask

    // Producer: hold in_valid until accepted (bounded).
    task automatic send(input logic [WIDTH-1:0] t);
        int unsigned n = 0;
        do begin
            cycle(1'b0, 1'b1, t);
            n++;
        end while (!m_accepted && n < 64);
        if (!m_accepted) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (!m_idle() && n < 64) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        if (!m_idle()) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);           // post-reset idle checks

        send(8'h05); drain();
        check("seq05_shadow", 32'(q_shadow), 32'h05);
        send(8'h05); drain();            // n=0 transfer
        send(8'h80); drain();
        check("seq80_shadow", 32'(q_shadow), 32'h80);

        cycle(1'b1, 1'b0, '0);
        send(8'hFF);
        repeat (3) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);           // reset mid-STEP
        cycle(1'b0, 1'b0, '0);
        check("rst_mid_shadow", 32'(q_shadow), 32'h00);

        send(8'h03);
        send(8'h0F); drain();            // held while busy, taken on first ready

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) cycle(1'b1, 1'b0, '0);
            else cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
